// File: rtl/serie_paralelo_1a8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serie_paralelo_1a8_pkg
// Description : Shared constants and state encoding for the 1-to-8 deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package serie_paralelo_1a8_pkg;

    localparam logic [7:0]  C_COMMA_DEFAULT      = 8'hBC;
    localparam int unsigned C_SYNC_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/serie_paralelo_1a8_comma_detector.sv
`default_nettype none
// ============================================================================
// Module      : serie_paralelo_1a8_comma_detector
// Description : Full-byte compare of a candidate byte against the comma symbol.
// Revision    : 1.0 - initial release
// ============================================================================
module serie_paralelo_1a8_comma_detector
    import serie_paralelo_1a8_pkg::*;
#(
    parameter logic [7:0] COMMA = C_COMMA_DEFAULT
) (
    input  logic [7:0] byte_i,
    output logic       match_o
);

    assign match_o = (byte_i == COMMA);

endmodule
`default_nettype wire

// File: rtl/serie_paralelo_1a8.sv
`default_nettype none
// ============================================================================
// Module      : serie_paralelo_1a8
// Description : Serial-to-parallel converter with comma-based byte alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module serie_paralelo_1a8
    import serie_paralelo_1a8_pkg::*;
#(
    parameter logic [7:0]  COMMA      = C_COMMA_DEFAULT,
    parameter int unsigned SYNC_COUNT = C_SYNC_COUNT_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [2:0] C_SYNC = 3'(SYNC_COUNT);

    state_e     state_q,   state_d;
    logic [6:0] shift_q,   shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] bc_cnt_q,  bc_cnt_d;
    logic [7:0] data_q,    data_d;
    logic       valid_q,   valid_d;

    logic [7:0] w_byte_next;
    logic       w_is_comma;
    logic       w_byte_done;

    assign w_byte_next = {shift_q, data_in};
    assign w_byte_done = (bit_cnt_q == 3'd7);

    serie_paralelo_1a8_comma_detector #(
        .COMMA   (COMMA)
    ) u_comma_detector (
        .byte_i  (w_byte_next),
        .match_o (w_is_comma)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = w_byte_next[6:0];
        bit_cnt_d = bit_cnt_q;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        case (state_q)
            SEARCH: begin
                bit_cnt_d = 3'd0;
                if (w_is_comma) begin
                    bc_cnt_d = 3'd1;
                    state_d  = (C_SYNC == 3'd1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                // Only byte-aligned commas count; a mismatch discards the partial lock.
                if (w_byte_done) begin
                    if (w_is_comma) begin
                        bc_cnt_d = bc_cnt_q + 3'd1;
                        if ((bc_cnt_q + 3'd1) == C_SYNC) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        bc_cnt_d = 3'd0;
                        state_d  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (w_byte_done) begin
                    if (w_is_comma) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = w_byte_next;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q   <= SEARCH;
            shift_q   <= 7'd0;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 3'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = (state_q == ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_serie_paralelo_1a8.sv
`default_nettype none
// ============================================================================
// Module      : tb_serie_paralelo_1a8
// Description : Randomized and directed bench for the 1-to-8 deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serie_paralelo_1a8;

    localparam logic [7:0] C_COMMA = 8'hBC;
    localparam int         C_SYNC  = 4;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: last eight received bits, lock progress and held output byte.
    logic [7:0] m_hist;
    bit         m_locked;
    bit         m_aligning;
    int         m_phase;
    int         m_commas;
    logic [7:0] m_data;
    logic       m_valid;

    serie_paralelo_1a8 #(
        .COMMA      (C_COMMA),
        .SYNC_COUNT (C_SYNC)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_data"},   data_out,         m_data);
        check({tag, "_valid"},  {7'd0, valid_out}, {7'd0, m_valid});
        check({tag, "_active"}, {7'd0, active},    {7'd0, m_locked});
    endtask

    task automatic model_reset();
        m_hist = 8'h00; m_locked = 0; m_aligning = 0;
        m_phase = 0; m_commas = 0; m_data = 8'h00; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic b);
        logic [7:0] bn;
        bn = {m_hist[6:0], b};
        m_hist = bn;
        if (!m_locked && !m_aligning) begin
            if (bn == C_COMMA) begin
                m_commas = 1;
                m_phase  = 0;
                if (m_commas == C_SYNC) m_locked = 1;
                else                    m_aligning = 1;
            end
        end else begin
            m_phase++;
            if (m_phase == 8) begin
                m_phase = 0;
                if (m_aligning) begin
                    if (bn == C_COMMA) begin
                        m_commas++;
                        if (m_commas == C_SYNC) begin
                            m_aligning = 0;
                            m_locked   = 1;
                        end
                    end else begin
                        m_aligning = 0;
                        m_commas   = 0;
                    end
                end else if (bn != C_COMMA) begin
                    m_data  = bn;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        model_step(b);
        #1;
        check_outputs("cyc");
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Asserted between edges so the clear must happen without a clock.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        data_in = 1'b0;
        model_reset();
        repeat (4) @(posedge clk_32f);
        #1;
        check_outputs("reset");
        reset = 1'b1;

        // Four aligned commas lock on the LSB of the fourth.
        for (int k = 0; k < 4; k++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(C_COMMA[i]);
                if (k == 3 && i == 1) check("t1_prelock", {7'd0, active}, 8'd0);
            end
        end
        check("t1_lock", {7'd0, active}, 8'd1);

        send_byte(8'hA5);
        check("t2_a5", data_out, 8'hA5);
        send_byte(8'h3C);
        send_byte(C_COMMA);
        check("t2_comma_hold", data_out, 8'h3C);
        check("t2_comma_valid", {7'd0, valid_out}, 8'd0);
        send_byte(8'hFF);

        do_reset();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (4) send_byte(C_COMMA);
        send_byte(8'h12);

        do_reset();
        send_byte(C_COMMA); send_byte(C_COMMA); send_byte(8'h55);
        repeat (4) send_byte(C_COMMA);
        check("t4_relock", {7'd0, active}, 8'd1);

        send_byte(8'h77);
        for (int i = 7; i >= 4; i--) send_bit(1'(8'h77 >> i));
        do_reset();
        check("t5_active_cleared", {7'd0, active}, 8'd0);
        repeat (4) send_byte(C_COMMA);
        send_byte(8'h9A);

        do_reset();
        send_byte(8'h00);
        repeat (6) send_byte(8'h5E);

        for (int it = 0; it < 40; it++) begin
            do_reset();
            repeat ($urandom_range(0, 7)) send_bit(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) send_byte(C_COMMA);
            for (int j = 0; j < 8; j++) begin
                if ($urandom_range(0, 3) == 0) send_byte(C_COMMA);
                else                           send_byte(8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
